e203_exu_bjp_resolve: RTL and testbench
=======================================

Name: e203_exu_bjp_resolve

Overview:
- EXU-side counterpart of the IFU branch predictor: consumes resolved branch/jump results from the ALU BJP datapath and compares them with the IFU prediction carried down the pipe.
- On mismatch, issues a registered pipeline-flush request with the corrected next-PC to IFU and holds it until IFU acknowledges.
- Maintains saturating resolved-branch and mispredict counters for performance monitoring.

Parameters:
- PC_SIZE, 32, PC and target width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bjp_i_valid  in  1  resolved branch result valid.
- bjp_i_ready  out  1  block can accept a result.
- bjp_i_pc  in  PC_SIZE  PC of the branch instruction.
- bjp_i_rv32  in  1  1 = 32-bit instruction (length 4), 0 = 16-bit (length 2).
- bjp_i_prdt_taken  in  1  IFU prediction carried with the instruction.
- bjp_i_rslv_taken  in  1  ALU-resolved outcome; always 1 for jal/jalr.
- bjp_i_tgt  in  PC_SIZE  resolved taken target.
- pipe_flush_req  out  1  flush request to IFU.
- pipe_flush_ack  in  1  IFU accepts the flush.
- pipe_flush_pc  out  PC_SIZE  corrected fetch PC.
- cnt_clr  in  1  clear both counters.
- bjp_cnt  out  CNT_W  resolved-branch count.
- mis_cnt  out  CNT_W  mispredict count.

Behaviour:
- FSM states: IDLE, FLUSH. Reset to IDLE. Reset values: pipe_flush_req=0, pipe_flush_pc=0, bjp_cnt=0, mis_cnt=0.
- bjp_i_ready = (state==IDLE). This is combinational from state only and has no dependence on bjp_i_valid.
- A result is accepted when bjp_i_valid & bjp_i_ready.
- Mispredict is defined as bjp_i_prdt_taken != bjp_i_rslv_taken.
- Corrected PC:
  - If rslv_taken: bjp_i_tgt.
  - Otherwise: bjp_i_pc + (rv32 ? 4 : 2), computed modulo 2^PC_SIZE (wraps, no carry out).
- IDLE, on accept with mispredict:
  - Register the corrected PC into pipe_flush_pc.
  - Set pipe_flush_req=1 in the next cycle.
  - Go to FLUSH.
  - Latency from accept to req is exactly 1 cycle.
- IDLE, on accept with a correct prediction: stay in IDLE; no flush.
- FLUSH:
  - pipe_flush_req and pipe_flush_pc are held stable and bjp_i_ready=0.
  - On pipe_flush_ack, clear req at the next edge and return to IDLE.
  - The next result can be accepted in the cycle after the ack cycle.
- pipe_flush_ack while in IDLE is ignored.
- Counters:
  - bjp_cnt increments on every accept.
  - mis_cnt increments on every mispredict accept.
  - Both saturate at all-ones and never wrap.
- cnt_clr has priority over a same-cycle increment: counters read 0 the next cycle.
- rst asserted mid-FLUSH: the next edge forces IDLE, req=0, counters=0. Any pending flush is discarded.
- No combinational path from pipe_flush_ack to pipe_flush_req.

Test Plan:
- Correct prediction, no flush: accept pc=0x80000100, rv32=1, prdt=1, rslv=1, tgt=0x80000080.
  - Expect pipe_flush_req stays 0, bjp_cnt=1, mis_cnt=0.
- Predicted taken, resolved not taken: accept pc=0x80000100, rv32=1, prdt=1, rslv=0.
  - Next cycle pipe_flush_req=1 and pipe_flush_pc=0x80000104.
  - Hold ack low 3 cycles: req and pc stable, bjp_i_ready=0.
  - Ack: req=0 next cycle, mis_cnt=1.
- Predicted not taken, resolved taken: accept pc=0x2000, rv32=0, prdt=0, rslv=1, tgt=0x3000.
  - Expect pipe_flush_pc=0x3000.
  - Ack in the same cycle req rises: FSM returns to IDLE, and a back-to-back valid is accepted the cycle after the ack.
- Wrap: accept pc=0xFFFFFFFE, rv32=0, prdt=1, rslv=0.
  - Expect pipe_flush_pc=0x00000000.
- Counter saturation and clear, with CNT_W=4:
  - Drive 17 mispredicting accepts: bjp_cnt=mis_cnt=0xF.
  - Assert cnt_clr together with an accept: both counters read 0 the next cycle.
- Reset mid-flush: assert rst while pipe_flush_req=1.
  - Expect req=0, bjp_i_ready=1, and counters=0 the next cycle.
  - A later ack has no effect.

Source files
------------

// File: rtl/e203_exu_bjp_resolve.sv
// Purpose: checks resolved branch/jump outcomes against the IFU prediction and requests a pipeline flush with the corrected PC.
// Latency: the flush request is raised one cycle after the mispredicting result is accepted.
// Backpressure: bjp_i_ready is low while a flush is outstanding; it returns high the cycle after pipe_flush_ack.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   bjp_i_valid / bjp_i_ready   resolved-result handshake
//   bjp_i_pc, bjp_i_rv32        branch PC and instruction length (1 = 4 bytes, 0 = 2 bytes)
//   bjp_i_prdt_taken            IFU prediction carried with the instruction
//   bjp_i_rslv_taken            ALU-resolved outcome
//   bjp_i_tgt                   resolved taken target
//   pipe_flush_req / _ack / _pc flush request to IFU, its acknowledge, and the corrected fetch PC
//   cnt_clr, bjp_cnt, mis_cnt   performance counter clear and saturating counts
module e203_exu_bjp_resolve #(
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bjp_i_valid,
    output logic               bjp_i_ready,
    input  logic [PC_SIZE-1:0] bjp_i_pc,
    input  logic               bjp_i_rv32,
    input  logic               bjp_i_prdt_taken,
    input  logic               bjp_i_rslv_taken,
    input  logic [PC_SIZE-1:0] bjp_i_tgt,
    output logic               pipe_flush_req,
    input  logic               pipe_flush_ack,
    output logic [PC_SIZE-1:0] pipe_flush_pc,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bjp_cnt,
    output logic [CNT_W-1:0]   mis_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               mispredict;
    logic [PC_SIZE-1:0] pc_inc;
    logic [PC_SIZE-1:0] corr_pc;

    assign accept     = bjp_i_valid & bjp_i_ready;
    assign mispredict = bjp_i_prdt_taken ^ bjp_i_rslv_taken;
    assign pc_inc     = bjp_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);
    // Fall-through PC wraps modulo 2^PC_SIZE; the carry out is dropped on purpose.
    assign corr_pc    = bjp_i_rslv_taken ? bjp_i_tgt : (bjp_i_pc + pc_inc);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && mispredict) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (pipe_flush_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so ack never reaches req combinationally.
    always_comb begin
        bjp_i_ready    = (state == IDLE);
        pipe_flush_req = (state == FLUSH);
    end

    // Corrected PC is captured only when a flush is launched, so it stays stable throughout FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_flush_pc <= '0;
        end else if (accept && mispredict) begin
            pipe_flush_pc <= corr_pc;
        end
    end

    // Saturating counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bjp_cnt <= '0;
            mis_cnt <= '0;
        end else if (accept) begin
            if (bjp_cnt != {CNT_W{1'b1}}) begin
                bjp_cnt <= bjp_cnt + 1'b1;
            end
            if (mispredict && (mis_cnt != {CNT_W{1'b1}})) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_bjp_resolve.sv
// Purpose: self-checking bench for e203_exu_bjp_resolve (default 16-bit and 4-bit counter builds side by side).
// Latency: expectations follow a one-cycle accept-to-flush-request relation.
// Backpressure: stimulus respects bjp_i_ready implicitly; valid held during FLUSH must not be taken.
module tb_e203_exu_bjp_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        bjp_i_valid;
    logic [31:0] bjp_i_pc;
    logic        bjp_i_rv32;
    logic        bjp_i_prdt_taken;
    logic        bjp_i_rslv_taken;
    logic [31:0] bjp_i_tgt;
    logic        pipe_flush_ack;
    logic        cnt_clr;

    logic        rdy_a, req_a;
    logic [31:0] fpc_a;
    logic [15:0] bc_a, mc_a;
    logic        rdy_b, req_b;
    logic [31:0] fpc_b;
    logic [3:0]  bc_b, mc_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    e203_exu_bjp_resolve dut (
        .clk(clk), .rst(rst),
        .bjp_i_valid(bjp_i_valid), .bjp_i_ready(rdy_a),
        .bjp_i_pc(bjp_i_pc), .bjp_i_rv32(bjp_i_rv32),
        .bjp_i_prdt_taken(bjp_i_prdt_taken), .bjp_i_rslv_taken(bjp_i_rslv_taken),
        .bjp_i_tgt(bjp_i_tgt),
        .pipe_flush_req(req_a), .pipe_flush_ack(pipe_flush_ack), .pipe_flush_pc(fpc_a),
        .cnt_clr(cnt_clr), .bjp_cnt(bc_a), .mis_cnt(mc_a)
    );

    e203_exu_bjp_resolve #(.PC_SIZE(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .bjp_i_valid(bjp_i_valid), .bjp_i_ready(rdy_b),
        .bjp_i_pc(bjp_i_pc), .bjp_i_rv32(bjp_i_rv32),
        .bjp_i_prdt_taken(bjp_i_prdt_taken), .bjp_i_rslv_taken(bjp_i_rslv_taken),
        .bjp_i_tgt(bjp_i_tgt),
        .pipe_flush_req(req_b), .pipe_flush_ack(pipe_flush_ack), .pipe_flush_pc(fpc_b),
        .cnt_clr(cnt_clr), .bjp_cnt(bc_b), .mis_cnt(mc_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "a flush is pending" plus plain integer counts capped at the counter maximum.
    bit          m_pend;
    logic [31:0] m_pc;
    int unsigned m_bc, m_mc, m_bc4, m_mc4;

    always @(posedge clk) begin
        bit took;
        took = bjp_i_valid && !m_pend;
        if (rst) begin
            m_pend = 1'b0;
            m_pc   = 32'h0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else begin
            if (m_pend) begin
                if (pipe_flush_ack) m_pend = 1'b0;
            end else if (took && (bjp_i_prdt_taken != bjp_i_rslv_taken)) begin
                m_pend = 1'b1;
                m_pc   = bjp_i_rslv_taken ? bjp_i_tgt
                                          : bjp_i_pc + (bjp_i_rv32 ? 32'd4 : 32'd2);
            end
            if (cnt_clr) begin
                m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
            end else if (took) begin
                if (m_bc  < 65535) m_bc++;
                if (m_bc4 < 15)    m_bc4++;
                if (bjp_i_prdt_taken != bjp_i_rslv_taken) begin
                    if (m_mc  < 65535) m_mc++;
                    if (m_mc4 < 15)    m_mc4++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            check("m_ready",  32'(rdy_a), 32'(!m_pend));
            check("m_req",    32'(req_a), 32'(m_pend));
            check("m_pc",     fpc_a,      m_pc);
            check("m_bjpcnt", 32'(bc_a),  m_bc);
            check("m_miscnt", 32'(mc_a),  m_mc);
            check("m4_ready", 32'(rdy_b), 32'(!m_pend));
            check("m4_req",   32'(req_b), 32'(m_pend));
            check("m4_pc",    fpc_b,      m_pc);
            check("m4_bjpcnt",32'(bc_b),  m_bc4);
            check("m4_miscnt",32'(mc_b),  m_mc4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic rv32, input logic prdt,
                         input logic rslv, input logic [31:0] tgt);
        bjp_i_valid      = 1'b1;
        bjp_i_pc         = pc;
        bjp_i_rv32       = rv32;
        bjp_i_prdt_taken = prdt;
        bjp_i_rslv_taken = rslv;
        bjp_i_tgt        = tgt;
    endtask

    initial begin
        rst = 1'b1; bjp_i_valid = 1'b0; bjp_i_pc = '0; bjp_i_rv32 = 1'b0;
        bjp_i_prdt_taken = 1'b0; bjp_i_rslv_taken = 1'b0; bjp_i_tgt = '0;
        pipe_flush_ack = 1'b0; cnt_clr = 1'b0;
        step();
        run = 1'b1;
        step();
        check("rst_req",   32'(req_a), 32'd0);
        check("rst_pc",    fpc_a,      32'd0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_cnt",   32'(bc_a),  32'd0);
        check("rst_mis",   32'(mc_a),  32'd0);
        rst = 1'b0;

        // Correct prediction: no flush.
        drive(32'h8000_0100, 1'b1, 1'b1, 1'b1, 32'h8000_0080);
        step();
        bjp_i_valid = 1'b0;
        check("ok_req", 32'(req_a), 32'd0);
        check("ok_cnt", 32'(bc_a),  32'd1);
        check("ok_mis", 32'(mc_a),  32'd0);
        step();
        check("ok_req2", 32'(req_a), 32'd0);

        // Predicted taken, resolved not taken; ack held off for 3 cycles.
        drive(32'h8000_0100, 1'b1, 1'b1, 1'b0, 32'h8000_0080);
        step();
        bjp_i_valid = 1'b0;
        check("nt_req", 32'(req_a), 32'd1);
        check("nt_pc",  fpc_a,      32'h8000_0104);
        for (int i = 0; i < 3; i++) begin
            step();
            check("nt_hold_req",   32'(req_a), 32'd1);
            check("nt_hold_pc",    fpc_a,      32'h8000_0104);
            check("nt_hold_ready", 32'(rdy_a), 32'd0);
        end
        pipe_flush_ack = 1'b1;
        step();
        pipe_flush_ack = 1'b0;
        check("nt_ack_req", 32'(req_a), 32'd0);
        check("nt_ack_mis", 32'(mc_a),  32'd1);
        check("nt_ack_cnt", 32'(bc_a),  32'd2);

        // Predicted not taken, resolved taken; ack in the cycle req rises, valid back-to-back.
        drive(32'h0000_2000, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
        step();
        check("tk_req", 32'(req_a), 32'd1);
        check("tk_pc",  fpc_a,      32'h0000_3000);
        pipe_flush_ack = 1'b1;
        drive(32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'h0000_4000);
        step();
        pipe_flush_ack = 1'b0;
        check("tk_ack_req",   32'(req_a), 32'd0);
        check("tk_ack_ready", 32'(rdy_a), 32'd1);
        check("tk_blocked",   32'(bc_a),  32'd3);
        step();
        bjp_i_valid = 1'b0;
        check("tk_b2b_cnt", 32'(bc_a),  32'd4);
        check("tk_b2b_mis", 32'(mc_a),  32'd2);
        check("tk_b2b_req", 32'(req_a), 32'd0);

        // Fall-through PC wraps past the top of the address space.
        drive(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'h1234_0000);
        step();
        bjp_i_valid = 1'b0;
        check("wrap_req", 32'(req_a), 32'd1);
        check("wrap_pc",  fpc_a,      32'h0000_0000);
        pipe_flush_ack = 1'b1;
        step();
        pipe_flush_ack = 1'b0;

        // Saturation: clear, then 17 mispredicting accepts.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(bc_a), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(32'h0000_1000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 32'h0000_8000 + 32'(i));
            step();
            bjp_i_valid = 1'b0;
            pipe_flush_ack = 1'b1;
            step();
            pipe_flush_ack = 1'b0;
        end
        check("sat4_cnt", 32'(bc_b), 32'h0000_000F);
        check("sat4_mis", 32'(mc_b), 32'h0000_000F);
        check("sat16_cnt", 32'(bc_a), 32'd17);
        check("sat16_mis", 32'(mc_a), 32'd17);
        check("sat_pc", fpc_a, 32'h0000_8010);

        // Clear together with an accept: clear wins, flush still launches.
        drive(32'h0000_5000, 1'b1, 1'b1, 1'b0, 32'h0000_0000);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        bjp_i_valid = 1'b0;
        check("clracc_cnt4", 32'(bc_b), 32'd0);
        check("clracc_mis4", 32'(mc_b), 32'd0);
        check("clracc_cnt",  32'(bc_a), 32'd0);
        check("clracc_req",  32'(req_a), 32'd1);
        check("clracc_pc",   fpc_a, 32'h0000_5004);
        pipe_flush_ack = 1'b1;
        step();
        pipe_flush_ack = 1'b0;

        // Reset in the middle of a flush.
        drive(32'h0000_6000, 1'b1, 1'b0, 1'b1, 32'h0000_7000);
        step();
        bjp_i_valid = 1'b0;
        check("rf_req_pre", 32'(req_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rf_req",   32'(req_a), 32'd0);
        check("rf_ready", 32'(rdy_a), 32'd1);
        check("rf_cnt",   32'(bc_a),  32'd0);
        check("rf_mis",   32'(mc_a),  32'd0);
        pipe_flush_ack = 1'b1;
        step();
        pipe_flush_ack = 1'b0;
        check("rf_ack_req",   32'(req_a), 32'd0);
        check("rf_ack_ready", 32'(rdy_a), 32'd1);
        step();
        step();

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
